// File: rtl/lcd_reader.sv
// rtl/lcd_reader.sv - HD44780 read-cycle sequencer: busy-flag/address or data-RAM read with optional busy polling.
// Optional feature macro: LCD_BUSY_POLL_EN (repeat rs=0 reads until bit 7 clears, bounded by POLL_TIMEOUT).
module lcd_reader #(
    parameter int CLOCK_DIVIDER = 16,
    parameter int SETUP_CYCLES  = 2,
    parameter int HOLD_CYCLES   = 2,
    parameter int POLL_TIMEOUT  = 4096
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic       rs,
    input  logic       poll,
    output logic [7:0] data_out,
    output logic       done,
    output logic       busy,
    output logic       timeout,
    input  logic [7:0] lcd_data_in,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en
);

    localparam int MAX_A = (SETUP_CYCLES > CLOCK_DIVIDER) ? SETUP_CYCLES : CLOCK_DIVIDER;
    localparam int MAX_T = (HOLD_CYCLES > MAX_A) ? HOLD_CYCLES : MAX_A;
    localparam int CW    = $clog2(MAX_T) + 1;

    localparam logic [CW-1:0] SETUP_LOAD = CW'(SETUP_CYCLES - 1);
    localparam logic [CW-1:0] EN_LOAD    = CW'(CLOCK_DIVIDER - 1);
    localparam logic [CW-1:0] HOLD_LOAD  = CW'(HOLD_CYCLES - 1);

    // FINISH never occupies a cycle; it is folded into the HOLD exit edge.
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        EN_HIGH,
        HOLD,
        FINISH
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          poll_more;
    logic          poll_expire;

`ifdef LCD_BUSY_POLL_EN
    localparam int PW = $clog2(POLL_TIMEOUT) + 1;

    logic          poll_flag;
    logic [PW-1:0] poll_cnt;

    always_comb begin
        poll_more   = 1'b0;
        poll_expire = 1'b0;
        if (poll_flag && data_out[7]) begin
            if ((32'(poll_cnt) + 1) < POLL_TIMEOUT)
                poll_more = 1'b1;
            else
                poll_expire = 1'b1;
        end
    end
`else
    logic unused_cfg;

    assign poll_more   = 1'b0;
    assign poll_expire = 1'b0;
    assign timeout     = 1'b0;
    assign unused_cfg  = poll ^ (POLL_TIMEOUT == 0);
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            data_out <= 8'h00;
            done     <= 1'b0;
            busy     <= 1'b0;
            lcd_rs   <= 1'b0;
            lcd_rw   <= 1'b0;
            lcd_en   <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
            timeout   <= 1'b0;
            poll_flag <= 1'b0;
            poll_cnt  <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        lcd_rs <= rs;
                        lcd_rw <= 1'b1;
                        busy   <= 1'b1;
                        done   <= 1'b0;
                        cnt    <= SETUP_LOAD;
                        state  <= SETUP;
`ifdef LCD_BUSY_POLL_EN
                        poll_flag <= poll & ~rs;
                        timeout   <= 1'b0;
                        poll_cnt  <= '0;
`endif
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        lcd_en <= 1'b1;
                        cnt    <= EN_LOAD;
                        state  <= EN_HIGH;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                EN_HIGH: begin
                    if (cnt == '0) begin
                        data_out <= lcd_data_in;
                        lcd_en   <= 1'b0;
                        cnt      <= HOLD_LOAD;
                        state    <= HOLD;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                HOLD: begin
                    if (cnt != '0) begin
                        cnt <= cnt - CW'(1);
                    end else if (poll_more) begin
                        cnt   <= SETUP_LOAD;
                        state <= SETUP;
`ifdef LCD_BUSY_POLL_EN
                        poll_cnt <= poll_cnt + PW'(1);
`endif
                    end else begin
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        lcd_rw <= 1'b0;
                        state  <= IDLE;
`ifdef LCD_BUSY_POLL_EN
                        timeout <= poll_expire;
`endif
                    end
                end
                default: begin
                    state  <= IDLE;
                    lcd_en <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_reader.sv
// tb/tb_lcd_reader.sv - directed self-checking bench for lcd_reader (default and POLL_TIMEOUT=3 instances).
module tb_lcd_reader;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic       rs;
    logic       poll;
    logic [7:0] lcd_data_in;

    logic [7:0] data_out, data_out3;
    logic       done, done3, busy, busy3, timeout, timeout3;
    logic       lcd_rs, lcd_rs3, lcd_rw, lcd_rw3, lcd_en, lcd_en3;

    int vectors     = 0;
    int miscompares = 0;
    int rises       = 0;
    int rises3      = 0;
    logic en_prev   = 1'b0;
    logic en3_prev  = 1'b0;

    always #5 clock = ~clock;

    lcd_reader u_dut (
        .clock(clock), .reset(reset), .start(start), .rs(rs), .poll(poll),
        .data_out(data_out), .done(done), .busy(busy), .timeout(timeout),
        .lcd_data_in(lcd_data_in), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en)
    );

    lcd_reader #(.POLL_TIMEOUT(3)) u_dut3 (
        .clock(clock), .reset(reset), .start(start), .rs(rs), .poll(poll),
        .data_out(data_out3), .done(done3), .busy(busy3), .timeout(timeout3),
        .lcd_data_in(lcd_data_in), .lcd_rs(lcd_rs3), .lcd_rw(lcd_rw3), .lcd_en(lcd_en3)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
        if (lcd_en && !en_prev) rises++;
        if (lcd_en3 && !en3_prev) rises3++;
        en_prev  = lcd_en;
        en3_prev = lcd_en3;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Leaves the bench just after accept edge 0.
    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; rs = 1'b0; poll = 1'b0; lcd_data_in = 8'h00;
        run(2);
        reset = 1'b0;
        check("rst_data_out", data_out, 8'h00);
        check("rst_done", done, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_rw", lcd_rw, 0);
        check("rst_lcd_en", lcd_en, 0);

        // Single data read
        rs = 1'b1; lcd_data_in = 8'h41; rises = 0;
        pulse_start();
        check("rd_e0_rw", lcd_rw, 1);
        check("rd_e0_rs", lcd_rs, 1);
        check("rd_e0_busy", busy, 1);
        check("rd_e0_en", lcd_en, 0);
        run(1);  check("rd_e1_en", lcd_en, 0);
        run(1);  check("rd_e2_en", lcd_en, 1);
        run(15); check("rd_e17_en", lcd_en, 1);
        check("rd_e17_rs", lcd_rs, 1);
        run(1);  check("rd_e18_en", lcd_en, 0);
        check("rd_e18_data", data_out, 8'h41);
        run(1);  check("rd_e19_done", done, 0);
        check("rd_e19_rw", lcd_rw, 1);
        run(1);  check("rd_e20_done", done, 1);
        check("rd_e20_busy", busy, 0);
        check("rd_e20_rw", lcd_rw, 0);
        check("rd_pulses", 8'(rises), 8'd1);

        // Start ignored while busy and on the done edge; accepted a cycle later
        rs = 1'b0; poll = 1'b0; lcd_data_in = 8'h3C; rises = 0;
        pulse_start();
        run(9);
        start = 1'b1; step(); start = 1'b0;
        run(9);  check("ign_e19_done", done, 0);
        check("ign_e19_busy", busy, 1);
        start = 1'b1;
        step();  check("ign_e20_done", done, 1);
        check("ign_e20_busy", busy, 0);
        check("ign_pulses", 8'(rises), 8'd1);
        step();  start = 1'b0;
        check("ign_e21_busy", busy, 1);
        check("ign_e21_done", done, 0);
        check("ign_e21_rw", lcd_rw, 1);
        run(20); check("ign_e41_done", done, 1);
        check("ign_e41_data", data_out, 8'h3C);
        check("ign_pulses2", 8'(rises), 8'd2);

        // Reset mid-read while lcd_en is high
        rs = 1'b1; lcd_data_in = 8'h5A;
        pulse_start();
        run(9);  check("mrst_e9_en", lcd_en, 1);
        reset = 1'b1; step(); reset = 1'b0;
        check("mrst_en", lcd_en, 0);
        check("mrst_rw", lcd_rw, 0);
        check("mrst_busy", busy, 0);
        check("mrst_done", done, 0);
        check("mrst_data", data_out, 8'h00);
        lcd_data_in = 8'h77;
        pulse_start();
        run(20); check("mrst_after_done", done, 1);
        check("mrst_after_data", data_out, 8'h77);

        // Busy poll: 0x80 for three reads then 0x05
        rs = 1'b0; poll = 1'b1; lcd_data_in = 8'h80; rises = 0; rises3 = 0;
        pulse_start();
        poll = 1'b0;
        run(20);
`ifdef LCD_BUSY_POLL_EN
        check("poll_e20_busy", busy, 1);
        check("poll_e20_done", done, 0);
`else
        check("np_e20_done", done, 1);
        check("np_e20_timeout", timeout, 0);
        check("np_e20_data", data_out, 8'h80);
        check("np_pulses", 8'(rises), 8'd1);
`endif
        run(38);
        lcd_data_in = 8'h05;
        run(2);
`ifdef LCD_BUSY_POLL_EN
        check("to_done", done3, 1);
        check("to_timeout", timeout3, 1);
        check("to_data", data_out3, 8'h80);
        check("to_pulses", 8'(rises3), 8'd3);
        check("poll_e60_done", done, 0);
`endif
        run(19);
`ifdef LCD_BUSY_POLL_EN
        check("poll_e79_done", done, 0);
`endif
        run(1);
`ifdef LCD_BUSY_POLL_EN
        check("poll_e80_done", done, 1);
        check("poll_data", data_out, 8'h05);
        check("poll_timeout", timeout, 0);
        check("poll_pulses", 8'(rises), 8'd4);
`else
        check("np_e80_busy", busy, 0);
        check("np_pulses_end", 8'(rises), 8'd1);
        check("np_timeout3", timeout3, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
